// File: rtl/mmp_mixer_n_if.sv
// rtl/mmp_mixer_n_if.sv - sample strobe, channel data, gain bus and mix result of mmp_mixer_n
interface mmp_mixer_n_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 8,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                     i_SAMPLE_STB;
  logic [NUM_CH*IN_W-1:0]   i_CH_DATA;
  logic [NUM_CH-1:0]        i_MUTE;
  logic                     i_GAIN_WE;
  logic [SEL_W-1:0]         i_GAIN_SEL;
  logic [GAIN_W-1:0]        i_GAIN_DT;
  logic signed [OUT_W-1:0]  o_MIX;
  logic                     o_MIX_VLD;
  logic                     o_CLIP;
  logic                     o_BUSY;
  logic                     o_DROP;

  modport master (
    output i_SAMPLE_STB, i_CH_DATA, i_MUTE, i_GAIN_WE, i_GAIN_SEL, i_GAIN_DT,
    input  o_MIX, o_MIX_VLD, o_CLIP, o_BUSY, o_DROP
  );

  modport slave (
    input  i_SAMPLE_STB, i_CH_DATA, i_MUTE, i_GAIN_WE, i_GAIN_SEL, i_GAIN_DT,
    output o_MIX, o_MIX_VLD, o_CLIP, o_BUSY, o_DROP
  );
endinterface

// File: rtl/mmp_mixer_n.sv
// rtl/mmp_mixer_n.sv - time-multiplexed N-channel gain/mute mixer, one MAC per clock, saturating output
module mmp_mixer_n #(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int GAIN_W    = 8,
  parameter int FRAC_BITS = 6,
  parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  mmp_mixer_n_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = IN_W + GAIN_W + 1;
  localparam int ACC_W = PW + $clog2(NUM_CH);
  localparam logic [GAIN_W-1:0] UNITY   = GAIN_W'(2 ** FRAC_BITS);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t                   r_state;
  logic [CH_W-1:0]          r_ch;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [IN_W-1:0]   r_data [NUM_CH];
  logic [NUM_CH-1:0]        r_mute;
  logic [GAIN_W-1:0]        r_gain_sh  [NUM_CH];
  logic [GAIN_W-1:0]        r_gain_act [NUM_CH];
  logic signed [OUT_W-1:0]  r_mix;
  logic                     r_vld;
  logic                     r_clip;
  logic                     r_busy;
  logic                     r_drop;

  logic signed [IN_W-1:0]   w_samp;
  logic signed [PW-1:0]     w_samp_x;
  logic signed [PW-1:0]     w_gain_x;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_term;
  logic signed [ACC_W-1:0]  w_term_x;
  logic signed [ACC_W-1:0]  w_shift;
  logic [ACC_W-OUT_W:0]     w_hi;
  logic                     w_fits;
  logic signed [OUT_W-1:0]  w_sat;
  logic                     w_accept;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign w_samp   = r_data[r_ch];
  assign w_samp_x = {{(PW-IN_W){w_samp[IN_W-1]}}, w_samp};
  assign w_gain_x = {{(PW-GAIN_W){1'b0}}, r_gain_act[r_ch]};
  assign w_prod   = w_samp_x * w_gain_x;
  assign w_term   = r_mute[r_ch] ? '0 : w_prod;
  assign w_term_x = {{(ACC_W-PW){w_term[PW-1]}}, w_term};

  // Result fits OUT_W when every bit from the OUT_W sign position upward agrees.
  assign w_shift  = r_acc >>> FRAC_BITS;
  assign w_hi     = w_shift[ACC_W-1:OUT_W-1];
  assign w_fits   = (&w_hi) | ~(|w_hi);
  assign w_sat    = w_fits ? w_shift[OUT_W-1:0] :
                    (w_shift[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
  assign w_accept = bus.i_SAMPLE_STB && (r_state == S_IDLE);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_acc   <= '0;
      r_mute  <= '0;
      r_mix   <= '0;
      r_vld   <= 1'b0;
      r_clip  <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_data[k]     <= '0;
        r_gain_sh[k]  <= UNITY;
        r_gain_act[k] <= UNITY;
      end
    end else begin
      r_vld  <= 1'b0;
      r_drop <= bus.i_SAMPLE_STB && (r_state != S_IDLE);
      // Copy reads the old shadow, so a same-cycle write applies from the next sample.
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_accept)
          r_gain_act[k] <= r_gain_sh[k];
        if (bus.i_GAIN_WE && ({1'b0, bus.i_GAIN_SEL} == k[SEL_W:0]))
          r_gain_sh[k] <= bus.i_GAIN_DT;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < NUM_CH; k++)
              r_data[k] <= $signed(bus.i_CH_DATA[k*IN_W +: IN_W]);
            r_mute  <= bus.i_MUTE;
            r_acc   <= '0;
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= r_acc + w_term_x;
          r_ch  <= r_ch + 1'b1;
          if (r_ch == LAST_CH)
            r_state <= S_OUT;
        end
        S_OUT: begin
          r_mix   <= w_sat;
          r_clip  <= ~w_fits;
          r_vld   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_MIX     = r_mix;
  assign bus.o_MIX_VLD = r_vld;
  assign bus.o_CLIP    = r_clip;
  assign bus.o_BUSY    = r_busy;
  assign bus.o_DROP    = r_drop;
endmodule

// File: tb/tb_mmp_mixer_n.sv
// tb/tb_mmp_mixer_n.sv - scoreboard testbench for mmp_mixer_n
module tb_mmp_mixer_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmp_mixer_n_if #(.NUM_CH(4), .IN_W(16), .OUT_W(16), .GAIN_W(8), .SEL_W(3)) bus ();

  mmp_mixer_n #(.NUM_CH(4), .IN_W(16), .OUT_W(16), .GAIN_W(8), .FRAC_BITS(6), .SEL_W(3)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic signed [15:0] mix;
    logic               clip;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   vld_cnt  = 0;
  int   m_gain [4];

  always @(negedge clk) begin
    if (bus.o_MIX_VLD === 1'b1) begin
      exp_t e;
      vld_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vld: o_MIX=%0d with empty scoreboard", bus.o_MIX);
      end else begin
        e = sb.pop_front();
        if (bus.o_MIX !== e.mix || bus.o_CLIP !== e.clip) begin
          failures++;
          $display("FAIL mix_result: got mix=%0d clip=%0b, expected mix=%0d clip=%0b",
                   bus.o_MIX, bus.o_CLIP, e.mix, e.clip);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int mix, input logic clip);
    exp_t e;
    e.mix  = 16'(mix);
    e.clip = clip;
    sb.push_back(e);
  endtask

  task automatic gain_wr(input int sel, input int val);
    bus.i_GAIN_WE  = 1'b1;
    bus.i_GAIN_SEL = sel[2:0];
    bus.i_GAIN_DT  = val[7:0];
    tick();
    bus.i_GAIN_WE  = 1'b0;
    if (sel < 4) m_gain[sel] = val;
  endtask

  task automatic strobe(input logic signed [15:0] d0, d1, d2, d3, input logic [3:0] m);
    bus.i_CH_DATA    = {d3, d2, d1, d0};
    bus.i_MUTE       = m;
    bus.i_SAMPLE_STB = 1'b1;
    tick();
    bus.i_SAMPLE_STB = 1'b0;
    bus.i_CH_DATA    = {$urandom(), $urandom()};
    bus.i_MUTE       = 4'($urandom());
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.o_MIX_VLD === 1'b1) seen = 1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: o_MIX_VLD=0 after 20 cycles, expected 1", name);
    end
  endtask

  function automatic exp_t model(input logic [63:0] d, input logic [3:0] m);
    longint acc = 0;
    longint r;
    exp_t   e;
    for (int k = 0; k < 4; k++)
      if (!m[k]) acc += longint'($signed(d[k*16 +: 16])) * longint'(m_gain[k]);
    r = acc >>> 6;
    if (r > 32767)       begin e.mix = 16'sd32767;  e.clip = 1'b1; end
    else if (r < -32768) begin e.mix = -16'sd32768; e.clip = 1'b1; end
    else                 begin e.mix = 16'(r);      e.clip = 1'b0; end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.o_MIX, bus.o_MIX_VLD, bus.o_CLIP, bus.o_BUSY, bus.o_DROP} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got mix=%0d vld=%0b clip=%0b busy=%0b drop=%0b, expected all 0",
               bus.o_MIX, bus.o_MIX_VLD, bus.o_CLIP, bus.o_BUSY, bus.o_DROP);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unity;
    push(1100, 1'b0);
    strobe(16'sd1000, -16'sd200, 16'sd300, 16'sd0, 4'b0000);
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (bus.o_BUSY !== (i < 5) || bus.o_MIX_VLD !== (i == 5)) begin
        failures++;
        $display("FAIL unity_latency edge %0d: got busy=%0b vld=%0b, expected busy=%0b vld=%0b",
                 i, bus.o_BUSY, bus.o_MIX_VLD, (i < 5), (i == 5));
      end
      if (i < 5) tick();
    end
    tick();
  endtask

  task automatic test_saturation;
    gain_wr(0, 128);
    push(32767, 1'b1);
    strobe(16'sd20000, 16'sd20000, 16'sd20000, 16'sd20000, 4'b0000);
    wait_done("sat_pos");
    tick();
    push(-32768, 1'b1);
    strobe(-16'sd20000, -16'sd20000, -16'sd20000, -16'sd20000, 4'b0000);
    wait_done("sat_neg");
    tick();
    gain_wr(0, 64);
  endtask

  task automatic test_floor;
    gain_wr(0, 32);
    push(-2, 1'b0);
    strobe(-16'sd3, 16'sd0, 16'sd0, 16'sd0, 4'b0000);
    wait_done("floor_neg");
    tick();
    push(1, 1'b0);
    strobe(16'sd3, 16'sd0, 16'sd0, 16'sd0, 4'b0000);
    wait_done("floor_pos");
    tick();
    gain_wr(0, 64);
  endtask

  task automatic test_mute_oor;
    push(300, 1'b0);
    strobe(16'sd100, 16'sd5000, 16'sd100, 16'sd100, 4'b0010);
    wait_done("mute");
    tick();
    gain_wr(4, 0);
    gain_wr(7, 0);
    push(1000, 1'b0);
    strobe(16'sd100, 16'sd200, 16'sd300, 16'sd400, 4'b0000);
    wait_done("oor");
    tick();
  endtask

  task automatic test_busy;
    push(4000, 1'b0);
    strobe(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 4'b0000);
    tick();
    bus.i_SAMPLE_STB = 1'b1;
    bus.i_CH_DATA    = {4{16'sd5}};
    bus.i_GAIN_WE    = 1'b1;
    bus.i_GAIN_SEL   = 3'd1;
    bus.i_GAIN_DT    = 8'd0;
    tick();
    bus.i_SAMPLE_STB = 1'b0;
    bus.i_GAIN_WE    = 1'b0;
    m_gain[1]        = 0;
    checks++;
    if (bus.o_DROP !== 1'b1 || bus.o_MIX !== 16'sd1000) begin
      failures++;
      $display("FAIL busy_drop: got drop=%0b mix=%0d, expected drop=1 mix=1000", bus.o_DROP, bus.o_MIX);
    end
    tick();
    checks++;
    if (bus.o_DROP !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop_once: got drop=%0b, expected 0", bus.o_DROP);
    end
    wait_done("busy_cur");
    tick();
    push(3000, 1'b0);
    strobe(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 4'b0000);
    wait_done("busy_next");
    tick();
    gain_wr(1, 64);
  endtask

  task automatic test_back_to_back;
    push(10, 1'b0);
    strobe(16'sd10, 16'sd0, 16'sd0, 16'sd0, 4'b0000);
    wait_done("b2b_first");
    push(-50, 1'b0);
    strobe(16'sd0, -16'sd50, 16'sd0, 16'sd0, 4'b0000);
    checks++;
    if (bus.o_DROP !== 1'b0 || bus.o_BUSY !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got drop=%0b busy=%0b, expected drop=0 busy=1", bus.o_DROP, bus.o_BUSY);
    end
    wait_done("b2b_second");
    tick();
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    gain_wr(2, 0);
    strobe(16'sd7, 16'sd7, 16'sd7, 16'sd7, 4'b0000);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) m_gain[k] = 64;
    checks++;
    if ({bus.o_MIX, bus.o_MIX_VLD, bus.o_CLIP, bus.o_BUSY, bus.o_DROP} !== 20'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got mix=%0d vld=%0b clip=%0b busy=%0b drop=%0b, expected all 0",
               bus.o_MIX, bus.o_MIX_VLD, bus.o_CLIP, bus.o_BUSY, bus.o_DROP);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.o_MIX_VLD === 1'b1) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_novld: got o_MIX_VLD=1 after abort, expected 0");
    end
    push(100, 1'b0);
    strobe(16'sd10, 16'sd20, 16'sd30, 16'sd40, 4'b0000);
    wait_done("midreset_unity");
    tick();
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic [3:0]  m;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 4; k++) gain_wr(k, int'($urandom_range(0, 200)));
      d = {$urandom(), $urandom()};
      m = 4'($urandom());
      sb.push_back(model(d, m));
      strobe(d[15:0], d[31:16], d[47:32], d[63:48], m);
      wait_done("random");
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m_gain[k] = 64;
    bus.i_SAMPLE_STB = 1'b0;
    bus.i_CH_DATA    = '0;
    bus.i_MUTE       = '0;
    bus.i_GAIN_WE    = 1'b0;
    bus.i_GAIN_SEL   = '0;
    bus.i_GAIN_DT    = '0;
    test_reset();
    test_unity();
    test_saturation();
    test_floor();
    test_mute_oor();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
